// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with integrated MEM/WB register.
//
// Converts M-stage load/store instructions into request/grant/read-valid bus
// transactions (at most one outstanding). It steers bytes onto the correct
// lanes, sign- or zero-extends load data, and flags misaligned or illegal
// accesses. It holds stall_m high until each access completes. Instructions
// that do not access memory, and faulting accesses, go straight to writeback.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_m             M-stage instruction valid
//   mem_read_m/_write_m load / store request
//   funct3_m            RISC-V load/store funct3 (size + unsigned flag)
//   addr_m, wdata_m     effective byte address, right-aligned store data
//   rd_m, reg_write_m, result_src_m, pc_plus4_m   sideband forwarded to WB
//   stall_m             freezes IF/ID/EX/M while an access is in flight
//   mem_req/we/addr/be/wdata   bus request (word-aligned address, lane enables)
//   mem_gnt, mem_rvalid, mem_rdata   bus grant and read return
//   valid_w, reg_write_w, rd_w, result_src_w, pc_plus4_w,
//   alu_result_w, load_data_w, fault_w     MEM/WB register outputs
module mem_stage_lsu #(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] addr_m,
    input  logic [XLEN-1:0] wdata_m,
    input  logic [4:0]      rd_m,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    output logic            stall_m,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [NB-1:0]   mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            valid_w,
    output logic            reg_write_w,
    output logic [4:0]      rd_w,
    output logic [1:0]      result_src_w,
    output logic [XLEN-1:0] pc_plus4_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] load_data_w,
    output logic            fault_w
);

    localparam int LW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_nx;

    logic            access;
    logic            misaligned;
    logic            illegal;
    logic            fault;
    logic [LW-1:0]   lane;
    logic [NB-1:0]   size_mask;
    logic            latch_req;
    logic            capture;

    logic [2:0]      funct3_q;
    logic [LW-1:0]   lane_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;

    assign access = valid_m & (mem_read_m | mem_write_m);
    assign lane   = addr_m[LW-1:0];

    // Access size, alignment and funct3 legality decode.
    always_comb begin
        size_mask  = '0;
        misaligned = 1'b0;
        case (funct3_m[1:0])
            2'b00: size_mask[0] = 1'b1;
            2'b01: begin
                size_mask[1:0] = '1;
                misaligned     = addr_m[0];
            end
            2'b10: begin
                size_mask[3:0] = '1;
                misaligned     = |addr_m[1:0];
            end
            default: begin
                size_mask  = '1;
                misaligned = |lane;
            end
        endcase

        illegal = (funct3_m == 3'b111)
               || ((XLEN != 64) && (funct3_m[1:0] == 2'b11))
               || ((XLEN != 64) && mem_read_m && (funct3_m == 3'b110));
    end

    assign fault = access & (misaligned | illegal);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        latch_req = 1'b0;
        capture   = 1'b0;
        mem_req   = 1'b0;
        stall_m   = 1'b0;
        case (state)
            IDLE: begin
                if (access && !fault) begin
                    state_nx  = REQ;
                    latch_req = 1'b1;
                    stall_m   = 1'b1;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                stall_m = 1'b1;
                if (mem_gnt) begin
                    if (mem_we) begin
                        state_nx = DONE;
                    end else if (mem_rvalid) begin
                        state_nx = DONE;
                        capture  = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_m = 1'b1;
                if (mem_rvalid) begin
                    state_nx = DONE;
                    capture  = 1'b1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus-side request registers. They are loaded only on REQ entry, so the
    // bus outputs are held steady until the grant arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            funct3_q  <= '0;
            lane_q    <= '0;
            rdata_q   <= '0;
        end else begin
            if (latch_req) begin
                mem_we    <= mem_write_m;
                mem_addr  <= {addr_m[XLEN-1:LW], {LW{1'b0}}};
                mem_be    <= size_mask << lane;
                mem_wdata <= wdata_m << {lane, 3'b000};
                funct3_q  <= funct3_m;
                lane_q    <= lane;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Load alignment and extension. funct3[2] selects zero extension.
    assign rdata_shifted = rdata_q >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = XLEN'($signed(rdata_shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(rdata_shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(rdata_shifted[31:0]));
            3'b100:  load_ext = XLEN'(rdata_shifted[7:0]);
            3'b101:  load_ext = XLEN'(rdata_shifted[15:0]);
            3'b110:  load_ext = XLEN'(rdata_shifted[31:0]);
            default: load_ext = rdata_shifted;
        endcase
    end

    // MEM/WB register. It advances on every unstalled cycle. While an access
    // is in flight, the M-stage inputs stay frozen, so in DONE they still
    // describe the instruction that is completing.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            rd_w         <= '0;
            result_src_w <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            load_data_w  <= '0;
            fault_w      <= 1'b0;
        end else if (!stall_m) begin
            valid_w      <= valid_m;
            reg_write_w  <= valid_m & reg_write_m & ~fault;
            rd_w         <= rd_m;
            result_src_w <= result_src_m;
            pc_plus4_w   <= pc_plus4_m;
            alu_result_w <= addr_m;
            load_data_w  <= ((state == DONE) && !mem_we) ? load_ext : '0;
            fault_w      <= fault;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // XLEN=32 instance signals
    logic        valid_m, mem_read_m, mem_write_m, reg_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic [1:0]  result_src_m;
    logic        stall_m, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        valid_w, reg_write_w, fault_w;
    logic [4:0]  rd_w;
    logic [1:0]  result_src_w;
    logic [31:0] pc_plus4_w, alu_result_w, load_data_w;

    // XLEN=64 instance signals
    logic        valid_d, mem_read_d, mem_write_d, reg_write_d;
    logic [2:0]  funct3_d;
    logic [63:0] addr_d, wdata_d, pc_plus4_d;
    logic [4:0]  rd_d;
    logic [1:0]  result_src_d;
    logic        stall_d, mem_req_d, mem_we_d;
    logic [63:0] mem_addr_d, mem_wdata_d;
    logic [7:0]  mem_be_d;
    logic        mem_gnt_d, mem_rvalid_d;
    logic [63:0] mem_rdata_d;
    logic        valid_w_d, reg_write_w_d, fault_w_d;
    logic [4:0]  rd_w_d;
    logic [1:0]  result_src_w_d;
    logic [63:0] pc_plus4_w_d, alu_result_w_d, load_data_w_d;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .mem_read_m(mem_read_m),
        .mem_write_m(mem_write_m), .funct3_m(funct3_m), .addr_m(addr_m),
        .wdata_m(wdata_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .pc_plus4_m(pc_plus4_m), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .valid_w(valid_w), .reg_write_w(reg_write_w),
        .rd_w(rd_w), .result_src_w(result_src_w), .pc_plus4_w(pc_plus4_w),
        .alu_result_w(alu_result_w), .load_data_w(load_data_w), .fault_w(fault_w)
    );

    mem_stage_lsu #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .valid_m(valid_d), .mem_read_m(mem_read_d),
        .mem_write_m(mem_write_d), .funct3_m(funct3_d), .addr_m(addr_d),
        .wdata_m(wdata_d), .rd_m(rd_d), .reg_write_m(reg_write_d),
        .result_src_m(result_src_d), .pc_plus4_m(pc_plus4_d), .stall_m(stall_d),
        .mem_req(mem_req_d), .mem_we(mem_we_d), .mem_addr(mem_addr_d), .mem_be(mem_be_d),
        .mem_wdata(mem_wdata_d), .mem_gnt(mem_gnt_d), .mem_rvalid(mem_rvalid_d),
        .mem_rdata(mem_rdata_d), .valid_w(valid_w_d), .reg_write_w(reg_write_w_d),
        .rd_w(rd_w_d), .result_src_w(result_src_w_d), .pc_plus4_w(pc_plus4_w_d),
        .alu_result_w(alu_result_w_d), .load_data_w(load_data_w_d), .fault_w(fault_w_d)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          v, rd, wr, rw;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          gd, rvd;   // grant delay (extra REQ cycles), rvalid delay after grant
    } instr_t;

    typedef struct {
        bit          flt;
        logic [3:0]  be;
        logic [31:0] wsh, ld;
        int          stalls;
    } exp_t;

    typedef struct {
        string  name;
        instr_t i;
        exp_t   e;
    } vec_t;

    function automatic vec_t mk(input string name, input bit v, rd, wr, rw, input logic [2:0] f3,
                                input logic [31:0] addr, wdata, rdata, input int gd, rvd,
                                input bit flt, input logic [3:0] be, input logic [31:0] wsh, ld,
                                input int stalls);
        vec_t r;
        r.name = name;
        r.i.v = v; r.i.rd = rd; r.i.wr = wr; r.i.rw = rw; r.i.f3 = f3;
        r.i.addr = addr; r.i.wdata = wdata; r.i.rdata = rdata; r.i.gd = gd; r.i.rvd = rvd;
        r.e.flt = flt; r.e.be = be; r.e.wsh = wsh; r.e.ld = ld; r.e.stalls = stalls;
        return r;
    endfunction

    // Reference behaviour from the architectural rules (byte arithmetic).
    function automatic exp_t model32(input instr_t t);
        exp_t e;
        int size, lane;
        bit acc, illegal;
        longint unsigned mask, val;
        size    = 1 << t.f3[1:0];
        lane    = int'(t.addr % 4);
        acc     = t.v && (t.rd || t.wr);
        illegal = (t.f3 == 3'd7) || (t.f3[1:0] == 2'd3) || (t.rd && t.f3 == 3'd6);
        e.flt   = acc && (illegal || (t.addr % size) != 0);
        e.be    = 4'(((1 << size) - 1) << lane);
        e.wsh   = 32'(64'(t.wdata) << (8 * lane));
        mask    = (64'd1 << (8 * size)) - 1;
        val     = (64'(t.rdata) >> (8 * lane)) & mask;
        if (!t.f3[2] && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
        e.ld     = (acc && t.rd && !e.flt) ? val[31:0] : 32'd0;
        e.stalls = (acc && !e.flt) ? 2 + t.gd + (t.rd ? t.rvd : 0) : 0;
        return e;
    endfunction

    // Expected WB contents of the most recently completed instruction.
    bit          pend = 0;
    string       p_name;
    bit          p_v, p_rw, p_flt;
    logic [31:0] p_ld, p_alu, p_pc;
    logic [4:0]  p_rd;
    logic [1:0]  p_rs;

    task automatic check_pend();
        if (pend) begin
            chk({p_name, ".valid_w"}, valid_w, p_v);
            chk({p_name, ".reg_write_w"}, reg_write_w, p_rw);
            chk({p_name, ".fault_w"}, fault_w, p_flt);
            chk({p_name, ".load_data_w"}, load_data_w, p_ld);
            chk({p_name, ".alu_result_w"}, alu_result_w, p_alu);
            chk({p_name, ".rd_w"}, rd_w, p_rd);
            chk({p_name, ".result_src_w"}, result_src_w, p_rs);
            chk({p_name, ".pc_plus4_w"}, pc_plus4_w, p_pc);
            chk({p_name, ".req_after"}, mem_req, 1'b0);
            pend = 0;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check_pend();
        valid_m = 0; mem_read_m = 0; mem_write_m = 0; reg_write_m = 0;
        mem_gnt = 0; mem_rvalid = 0;
    endtask

    // Present one instruction in M, act as the bus slave, count stall cycles.
    task automatic run(input string name, input instr_t t, input exp_t e);
        int  req_seen, wait_cnt, stalls;
        bit  granted, done_ok;
        @(negedge clk);
        check_pend();
        valid_m = t.v; mem_read_m = t.rd; mem_write_m = t.wr; reg_write_m = t.rw;
        funct3_m = t.f3; addr_m = t.addr; wdata_m = t.wdata;
        rd_m = 5'($urandom); result_src_m = 2'($urandom); pc_plus4_m = $urandom;
        req_seen = 0; wait_cnt = 0; stalls = 0; granted = 0; done_ok = 0;
        for (int c = 0; c < 64; c++) begin
            if (c != 0) @(negedge clk);
            mem_gnt = 0; mem_rvalid = 0;
            if (mem_req) begin
                chk({name, ".mem_addr"}, mem_addr, t.addr & 32'hFFFF_FFFC);
                chk({name, ".mem_we"}, mem_we, t.wr);
                if (t.wr) begin
                    chk({name, ".mem_be"}, mem_be, e.be);
                    chk({name, ".mem_wdata"}, mem_wdata, e.wsh);
                end
                if (req_seen == t.gd) begin
                    mem_gnt = 1; granted = 1;
                    if (t.rd && t.rvd == 0) begin mem_rvalid = 1; mem_rdata = t.rdata; end
                end
                req_seen++;
            end else if (granted && t.rd && wait_cnt < t.rvd) begin
                wait_cnt++;
                mem_rdata = $urandom;
                if (wait_cnt == t.rvd) begin mem_rvalid = 1; mem_rdata = t.rdata; end
            end else if (c == 0 || granted) begin
                // Stray handshakes outside REQ/WAIT must be ignored.
                mem_rvalid = 1'($urandom); mem_gnt = 1'($urandom); mem_rdata = $urandom;
            end
            #1;
            if (!stall_m) begin done_ok = 1; break; end
            stalls++;
        end
        chk({name, ".completed"}, done_ok, 1'b1);
        chk({name, ".stall_cycles"}, stalls, e.stalls);
        pend = 1; p_name = name;
        p_v = t.v; p_rw = t.v && t.rw && !e.flt; p_flt = e.flt; p_ld = e.ld;
        p_alu = t.addr; p_rd = rd_m; p_rs = result_src_m; p_pc = pc_plus4_m;
    endtask

    vec_t tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1;
        valid_m = 0; mem_read_m = 0; mem_write_m = 0; reg_write_m = 0; funct3_m = 0;
        addr_m = 0; wdata_m = 0; pc_plus4_m = 0; rd_m = 0; result_src_m = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        valid_d = 0; mem_read_d = 0; mem_write_d = 0; reg_write_d = 0; funct3_d = 0;
        addr_d = 0; wdata_d = 0; pc_plus4_d = 0; rd_d = 0; result_src_d = 0;
        mem_gnt_d = 0; mem_rvalid_d = 0; mem_rdata_d = 0;

        //          name      v  rd wr rw f3      addr       wdata         rdata          gd rvd flt be     wsh            ld             st
        tbl.push_back(mk("sw",     1, 0, 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,         2, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0,         4));
        tbl.push_back(mk("lb",     1, 1, 0, 1, 3'b000, 32'h103, 32'h0,        32'h80FF1234,  0, 0, 0, 4'h0, 32'h0,        32'hFFFFFF80,  2));
        tbl.push_back(mk("lbu",    1, 1, 0, 1, 3'b100, 32'h103, 32'h0,        32'h80FF1234,  0, 0, 0, 4'h0, 32'h0,        32'h00000080,  2));
        tbl.push_back(mk("sh",     1, 0, 1, 0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,         0, 0, 0, 4'hC, 32'hABCD0000, 32'h0,         2));
        tbl.push_back(mk("lh_mis", 1, 1, 0, 1, 3'b001, 32'h101, 32'h0,        32'h5555,      0, 0, 1, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("add",    1, 0, 0, 1, 3'b000, 32'h55,  32'h0,        32'h0,         0, 0, 0, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("lw_slow",1, 1, 0, 1, 3'b010, 32'h200, 32'h0,        32'h12345678,  0, 5, 0, 4'h0, 32'h0,        32'h12345678,  7));
        tbl.push_back(mk("lhu",    1, 1, 0, 1, 3'b101, 32'h202, 32'h0,        32'h80010000,  1, 0, 0, 4'h0, 32'h0,        32'h00008001,  3));
        tbl.push_back(mk("lh",     1, 1, 0, 1, 3'b001, 32'h202, 32'h0,        32'h80010000,  0, 2, 0, 4'h0, 32'h0,        32'hFFFF8001,  4));
        tbl.push_back(mk("sb",     1, 0, 1, 0, 3'b000, 32'h101, 32'h12345678, 32'h0,         1, 0, 0, 4'h2, 32'h34567800, 32'h0,         3));
        tbl.push_back(mk("ld32",   1, 1, 0, 1, 3'b011, 32'h100, 32'h0,        32'h0,         0, 0, 1, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("lwu32",  1, 1, 0, 1, 3'b110, 32'h100, 32'h0,        32'h0,         0, 0, 1, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("f3_111", 1, 1, 0, 1, 3'b111, 32'h100, 32'h0,        32'h0,         0, 0, 1, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("sw_mis", 1, 0, 1, 0, 3'b010, 32'h102, 32'h1,        32'h0,         0, 0, 1, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("bubble", 0, 1, 0, 1, 3'b010, 32'h103, 32'h0,        32'h0,         0, 0, 0, 4'h0, 32'h0,        32'h0,         0));
        tbl.push_back(mk("sd32",   1, 0, 1, 0, 3'b011, 32'h100, 32'h7,        32'h0,         0, 0, 1, 4'h0, 32'h0,        32'h0,         0));

        repeat (2) @(negedge clk);
        chk("rst.stall_m", stall_m, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_be", mem_be, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.valid_w", valid_w, 0);
        chk("rst.reg_write_w", reg_write_w, 0);
        chk("rst.fault_w", fault_w, 0);
        chk("rst.load_data_w", load_data_w, 0);
        chk("rst.pc_plus4_w", pc_plus4_w, 0);
        chk("rst64.mem_req", mem_req_d, 0);
        chk("rst64.valid_w", valid_w_d, 0);
        rst = 0;

        for (int k = 0; k < tbl.size(); k++) run(tbl[k].name, tbl[k].i, tbl[k].e);

        for (int n = 0; n < 60; n++) begin
            instr_t t;
            int kind;
            kind   = $urandom_range(0, 3);
            t.v    = (kind != 3);
            t.rd   = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            t.wr   = (kind == 2);
            t.rw   = (kind != 2);
            t.f3   = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            t.addr = $urandom;
            if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.gd    = $urandom_range(0, 3);
            t.rvd   = $urandom_range(0, 4);
            run($sformatf("rnd%0d", n), t, model32(t));
        end
        idle_cycle();

        // Reset while waiting for read data; a late rvalid must be ignored.
        @(negedge clk);
        valid_m = 1; mem_read_m = 1; funct3_m = 3'b010; addr_m = 32'h300; reg_write_m = 1; rd_m = 5'd7;
        @(negedge clk);
        chk("rstw.req", mem_req, 1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1;
        chk("rstw.wait_stall", stall_m, 1);
        chk("rstw.wait_noreq", mem_req, 0);
        rst = 1;
        @(negedge clk);
        rst = 0; valid_m = 0; mem_read_m = 0; reg_write_m = 0;
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("rstw.stall_m", stall_m, 0);
        chk("rstw.mem_req", mem_req, 0);
        chk("rstw.mem_addr", mem_addr, 0);
        chk("rstw.mem_be", mem_be, 0);
        chk("rstw.valid_w", valid_w, 0);
        chk("rstw.reg_write_w", reg_write_w, 0);
        @(negedge clk);
        mem_rvalid = 0;
        chk("rstw.late_stall", stall_m, 0);
        chk("rstw.late_valid_w", valid_w, 0);
        @(negedge clk);
        chk("rstw.late_load_data", load_data_w, 0);
        chk("rstw.late_reg_write", reg_write_w, 0);
        chk("rstw.late_req", mem_req, 0);

        // XLEN=64: LWU from the upper word, then a misaligned LD.
        @(negedge clk);
        valid_d = 1; mem_read_d = 1; reg_write_d = 1; funct3_d = 3'b110; addr_d = 64'h14; rd_d = 5'd3;
        #1;
        chk("x64.lwu_stall_idle", stall_d, 1);
        @(negedge clk);
        chk("x64.lwu_req", mem_req_d, 1);
        chk("x64.lwu_addr", mem_addr_d, 64'h10);
        chk("x64.lwu_be", mem_be_d, 8'hF0);
        mem_gnt_d = 1; mem_rvalid_d = 1; mem_rdata_d = 64'h89ABCDEF_00000000;
        @(negedge clk);
        mem_gnt_d = 0; mem_rvalid_d = 0;
        #1;
        chk("x64.lwu_done_nostall", stall_d, 0);
        @(negedge clk);
        chk("x64.lwu_data", load_data_w_d, 64'h0000000089ABCDEF);
        chk("x64.lwu_fault", fault_w_d, 0);
        chk("x64.lwu_reg_write", reg_write_w_d, 1);
        funct3_d = 3'b011;
        #1;
        chk("x64.ld_nostall", stall_d, 0);
        @(negedge clk);
        valid_d = 0; mem_read_d = 0;
        chk("x64.ld_fault", fault_w_d, 1);
        chk("x64.ld_valid_w", valid_w_d, 1);
        chk("x64.ld_reg_write", reg_write_w_d, 0);
        chk("x64.ld_noreq", mem_req_d, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
